// File: rtl/pmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// pmem_arb_pkg
// Shared types and default widths for the physical-memory arbiter slice.
//   arb_state_e : arbiter FSM states
//   arb_id_e    : requester identity (used for last-grant tracking)
//   DEF_ADDR_W  : default byte-address width
//   DEF_LINE_W  : default cache-line / pmem data width
// -----------------------------------------------------------------------------
package pmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_I = 1'b0,
        ARB_D = 1'b1
    } arb_id_e;

endpackage

// File: rtl/pmem_req_reg.sv
// -----------------------------------------------------------------------------
// pmem_req_reg
// Register bank holding the request presented to pmem. Loaded once per grant
// and then held untouched until the transfer completes, so pmem sees a stable
// request regardless of what the caches do with their inputs meanwhile.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   load              : capture nxt_* into the bank
//   clear             : zero the bank (takes precedence over load)
//   nxt_read/write    : strobes to capture
//   nxt_address/wdata : address / write line to capture
//   read, write       : registered strobes to pmem
//   address, wdata    : registered address / write line to pmem
// -----------------------------------------------------------------------------
module pmem_req_reg
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic              nxt_read,
    input  logic              nxt_write,
    input  logic [ADDR_W-1:0] nxt_address,
    input  logic [LINE_W-1:0] nxt_wdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [LINE_W-1:0] wdata
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read    <= 1'b0;
            write   <= 1'b0;
            address <= '0;
            wdata   <= '0;
        end else if (clear) begin
            read    <= 1'b0;
            write   <= 1'b0;
            address <= '0;
            wdata   <= '0;
        end else if (load) begin
            read    <= nxt_read;
            write   <= nxt_write;
            address <= nxt_address;
            wdata   <= nxt_wdata;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
// Shares the single pmem line port between the I-cache (read-only) and the
// D-cache (read/write). One requester is granted at a time; its request is
// registered onto pmem and held until pmem_resp, and the response is routed
// back to the granted cache only.
//
// Optional feature: define PMEM_ARB_ROUND_ROBIN_EN to alternate grants when
// both caches request in the same IDLE cycle. Without it, D always wins.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   i_read, i_address                : I-cache line read request
//   i_resp, i_rdata                  : I-cache completion pulse and read line
//   d_read, d_write, d_address,
//   d_wdata                          : D-cache line request
//   d_resp, d_rdata                  : D-cache completion pulse and read line
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata         : registered request to pmem
//   pmem_resp, pmem_rdata            : pmem completion and read line
//
// State table
//   state   | meaning
//   IDLE    | no transfer; pmem strobes low; picks a winner from requests
//   SERVE_I | I-cache read in flight on pmem; waits for pmem_resp
//   SERVE_D | D-cache read or write in flight on pmem; waits for pmem_resp
// -----------------------------------------------------------------------------
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_e        state;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic              load;
    logic              clear;
    logic              nxt_read;
    logic              nxt_write;
    logic [ADDR_W-1:0] nxt_address;
    logic [LINE_W-1:0] nxt_wdata;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    arb_id_e           last_grant;
`endif

    // Winner select. Only meaningful in IDLE; load is gated by state below.
    always_comb begin
        d_req   = d_read | d_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        if (i_read && d_req) begin
            // Contention: hand the port to whoever did not have it last.
            grant_d = (last_grant == ARB_I);
            grant_i = (last_grant == ARB_D);
        end else begin
            grant_d = d_req;
            grant_i = i_read;
        end
`else
        grant_d = d_req;
        grant_i = i_read & ~d_req;
`endif
    end

    // Request capture. A D request with both strobes set is issued as a
    // write only, so pmem never sees read and write together.
    always_comb begin
        load        = (state == IDLE) && (grant_i || grant_d);
        clear       = (state != IDLE) && pmem_resp;
        nxt_write   = grant_d & d_write;
        nxt_read    = grant_i | (grant_d & ~d_write);
        nxt_address = grant_d ? d_address : i_address;
        nxt_wdata   = grant_d ? d_wdata : '0;
    end

    pmem_req_reg #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_req_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .clear       (clear),
        .nxt_read    (nxt_read),
        .nxt_write   (nxt_write),
        .nxt_address (nxt_address),
        .nxt_wdata   (nxt_wdata),
        .read        (pmem_read),
        .write       (pmem_write),
        .address     (pmem_address),
        .wdata       (pmem_wdata)
    );

    // Returning to IDLE after every completion gives the mandatory
    // one-cycle gap with strobes low between consecutive grants.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
            last_grant <= ARB_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state <= SERVE_D;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                        last_grant <= ARB_D;
`endif
                    end else if (grant_i) begin
                        state <= SERVE_I;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
                        last_grant <= ARB_I;
`endif
                    end
                end
                SERVE_I: if (pmem_resp) state <= IDLE;
                SERVE_D: if (pmem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Responses are forwarded combinationally to the granted side only;
    // a pmem_resp seen in IDLE reaches nobody.
    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
